// File: rtl/ocp_cpl_gen.sv
// ocp_cpl_gen: builds a 3DW CplD TLP from one read descriptor plus the OCP
// read-response DWs, and streams it as 64-bit AXI-stream beats to the TX FIFO.
// One completion in flight; a new descriptor is accepted only from IDLE.
module ocp_cpl_gen #(
    parameter logic [15:0] CPL_ID = 16'h0100,
    parameter int unsigned FIFO_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                desc_valid,
    output logic                desc_ready,
    input  logic [9:0]          desc_len,
    input  logic [15:0]         desc_req_id,
    input  logic [7:0]          desc_tag,
    input  logic [6:0]          desc_lo_addr,
    input  logic [1:0]          s_resp,
    input  logic [31:0]         s_data,
    output logic                m_resp_accept,
    output logic                s_axis_tvalid,
    input  logic                s_axis_tready,
    output logic [FIFO_W-1:0]   s_axis_tdata,
    output logic [FIFO_W/8-1:0] s_axis_tkeep,
    output logic                s_axis_tlast,
    output logic                err_seen
);

    localparam int unsigned DW_W   = 32;
    localparam int unsigned REM_W  = 11;
    localparam int unsigned KEEP_W = FIFO_W / 8;

    localparam logic [REM_W-1:0]  REM_MAX   = REM_W'(1024);
    localparam logic [KEEP_W-1:0] KEEP_FULL = {KEEP_W{1'b1}};
    localparam logic [KEEP_W-1:0] KEEP_LO   = KEEP_W'({(KEEP_W/2){1'b1}});
    localparam logic [2:0]        FMT_3DW_D = 3'b010;
    localparam logic [4:0]        TYPE_CPL  = 5'b01010;
    localparam logic [2:0]        STAT_SC   = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR0 = 2'd1,
        S_HDR1 = 2'd2,
        S_DATA = 2'd3
    } state_t;

    typedef struct packed {
        logic [15:0] req_id;
        logic [7:0]  tag;
        logic [6:0]  lo_addr;
    } desc_t;

    state_t              r_state;
    desc_t               r_desc;
    logic [REM_W-1:0]    r_rem;
    logic                r_half;
    logic [FIFO_W-1:0]   r_tdata;
    logic [KEEP_W-1:0]   r_tkeep;
    logic                r_tvalid;
    logic                r_tlast;
    logic                r_accept;
    logic                r_desc_ready;
    logic                r_err_seen;

    state_t              w_state_nxt;
    desc_t               w_desc_nxt;
    logic [REM_W-1:0]    w_rem_nxt;
    logic                w_half_nxt;
    logic [FIFO_W-1:0]   w_tdata_nxt;
    logic [KEEP_W-1:0]   w_tkeep_nxt;
    logic                w_tvalid_nxt;
    logic                w_tlast_nxt;
    logic                w_accept_nxt;
    logic                w_desc_ready_nxt;
    logic                w_err_seen_nxt;

    logic                w_take;
    logic                w_err;
    logic                w_hs;
    logic [DW_W-1:0]     w_dw;
    logic [DW_W-1:0]     w_dw0;
    logic [DW_W-1:0]     w_dw1;
    logic [DW_W-1:0]     w_dw2;
    logic [REM_W-1:0]    w_rem_dec;
    logic                w_rem_last;

    // Response/beat events and header DW assembly
    always_comb begin
        w_take     = (s_resp != 2'b00) && r_accept;
        w_err      = s_resp[1];
        w_dw       = w_err ? {DW_W{1'b1}} : s_data;
        w_hs       = r_tvalid && s_axis_tready;
        w_rem_dec  = r_rem - REM_W'(1);
        w_rem_last = (w_rem_dec == '0);
        w_dw0      = {FMT_3DW_D, TYPE_CPL, 14'b0, desc_len};
        w_dw1      = {CPL_ID, STAT_SC, 1'b0, desc_len, 2'b00};
        w_dw2      = {r_desc.req_id, r_desc.tag, 1'b0, r_desc.lo_addr};
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_desc       <= '0;
            r_rem        <= '0;
            r_half       <= 1'b0;
            r_tdata      <= '0;
            r_tkeep      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_accept     <= 1'b0;
            r_desc_ready <= 1'b0;
            r_err_seen   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_desc       <= w_desc_nxt;
            r_rem        <= w_rem_nxt;
            r_half       <= w_half_nxt;
            r_tdata      <= w_tdata_nxt;
            r_tkeep      <= w_tkeep_nxt;
            r_tvalid     <= w_tvalid_nxt;
            r_tlast      <= w_tlast_nxt;
            r_accept     <= w_accept_nxt;
            r_desc_ready <= w_desc_ready_nxt;
            r_err_seen   <= w_err_seen_nxt;
        end
    end

    // Next-state and next-output logic; a beat handshake is applied before a taken DW
    always_comb begin
        w_state_nxt      = r_state;
        w_desc_nxt       = r_desc;
        w_rem_nxt        = r_rem;
        w_half_nxt       = r_half;
        w_tdata_nxt      = r_tdata;
        w_tkeep_nxt      = r_tkeep;
        w_tvalid_nxt     = r_tvalid;
        w_tlast_nxt      = r_tlast;
        w_accept_nxt     = r_accept;
        w_desc_ready_nxt = r_desc_ready;
        w_err_seen_nxt   = r_err_seen || (w_take && w_err);

        case (r_state)
            S_IDLE: begin
                w_desc_ready_nxt = 1'b1;
                w_accept_nxt     = 1'b0;
                if (r_desc_ready && desc_valid) begin
                    w_desc_nxt.req_id  = desc_req_id;
                    w_desc_nxt.tag     = desc_tag;
                    w_desc_nxt.lo_addr = desc_lo_addr;
                    w_rem_nxt          = (desc_len == 10'd0) ? REM_MAX : REM_W'(desc_len);
                    w_half_nxt         = 1'b0;
                    w_tdata_nxt        = FIFO_W'({w_dw1, w_dw0});
                    w_tkeep_nxt        = KEEP_FULL;
                    w_tlast_nxt        = 1'b0;
                    w_tvalid_nxt       = 1'b1;
                    w_desc_ready_nxt   = 1'b0;
                    w_state_nxt        = S_HDR0;
                end
            end

            S_HDR0: begin
                if (w_hs) begin
                    w_tvalid_nxt = 1'b0;
                    w_accept_nxt = 1'b1;
                    w_state_nxt  = S_HDR1;
                end
            end

            S_HDR1: begin
                if (w_hs) begin
                    w_tvalid_nxt = 1'b0;
                    if (r_tlast) begin
                        w_state_nxt      = S_IDLE;
                        w_desc_ready_nxt = 1'b1;
                        w_accept_nxt     = 1'b0;
                    end else begin
                        w_state_nxt  = S_DATA;
                        w_accept_nxt = 1'b1;
                    end
                end
                if (w_take) begin
                    w_rem_nxt    = w_rem_dec;
                    w_tdata_nxt  = FIFO_W'({w_dw, w_dw2});
                    w_tkeep_nxt  = KEEP_FULL;
                    w_tlast_nxt  = w_rem_last;
                    w_tvalid_nxt = 1'b1;
                    w_accept_nxt = 1'b0;
                end
            end

            S_DATA: begin
                if (w_hs) begin
                    w_tvalid_nxt = 1'b0;
                    if (r_tlast) begin
                        w_state_nxt      = S_IDLE;
                        w_desc_ready_nxt = 1'b1;
                        w_accept_nxt     = 1'b0;
                    end else begin
                        w_accept_nxt = 1'b1;
                    end
                end
                if (w_take) begin
                    w_rem_nxt = w_rem_dec;
                    if (!r_half) begin
                        w_tdata_nxt = FIFO_W'({{DW_W{1'b0}}, w_dw});
                        if (w_rem_last) begin
                            w_tkeep_nxt  = KEEP_LO;
                            w_tlast_nxt  = 1'b1;
                            w_tvalid_nxt = 1'b1;
                            w_accept_nxt = 1'b0;
                        end else begin
                            w_half_nxt = 1'b1;
                        end
                    end else begin
                        w_tdata_nxt[2*DW_W-1:DW_W] = w_dw;
                        w_tkeep_nxt  = KEEP_FULL;
                        w_tlast_nxt  = w_rem_last;
                        w_tvalid_nxt = 1'b1;
                        w_accept_nxt = 1'b0;
                        w_half_nxt   = 1'b0;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign desc_ready    = r_desc_ready;
    assign m_resp_accept = r_accept;
    assign s_axis_tvalid = r_tvalid;
    assign s_axis_tdata  = r_tdata;
    assign s_axis_tkeep  = r_tkeep;
    assign s_axis_tlast  = r_tlast;
    assign err_seen      = r_err_seen;

endmodule

// File: tb/tb_ocp_cpl_gen.sv
// Bench for ocp_cpl_gen: table of completions with hand-computed header beats and
// beat counts, an OCP slave / AXI sink model, and a reset-mid-TLP sequence.
module tb_ocp_cpl_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        desc_valid;
    logic        desc_ready;
    logic [9:0]  desc_len;
    logic [15:0] desc_req_id;
    logic [7:0]  desc_tag;
    logic [6:0]  desc_lo_addr;
    logic [1:0]  s_resp;
    logic [31:0] s_data;
    logic        m_resp_accept;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        err_seen;

    ocp_cpl_gen #(.CPL_ID(16'h0100), .FIFO_W(64)) dut (
        .clk(clk), .reset(reset),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_len(desc_len),
        .desc_req_id(desc_req_id), .desc_tag(desc_tag), .desc_lo_addr(desc_lo_addr),
        .s_resp(s_resp), .s_data(s_data), .m_resp_accept(m_resp_accept),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .err_seen(err_seen)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [1:0] resp; logic [31:0] data; } rsp_t;
    typedef struct packed { logic [63:0] data; logic [7:0] keep; logic last; } beat_t;

    typedef struct {
        logic [9:0]  len;
        logic [15:0] req_id;
        logic [7:0]  tag;
        logic [6:0]  lo;
        logic [31:0] base;
        int          err_idx;
        logic [1:0]  err_code;
        int          tr_mode;
        int          gap;
        logic [63:0] exp_beat0;
        int          exp_nbeats;
        logic [7:0]  exp_last_keep;
        logic        exp_err;
    } vec_t;

    rsp_t  rsp_q[$];
    beat_t rx_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_taken = 0;
    int    tr_mode = 0;
    int    gap_mode = 0;
    vec_t  vecs[7];
    vec_t  vpost[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // OCP slave and AXI sink: sample at negedge, drive just after posedge
    initial begin : bus_model
        bit    stall_pend;
        bit    took;
        beat_t stall_beat;
        stall_pend = 1'b0;
        forever begin
            @(negedge clk);
            took = 1'b0;
            if (reset) begin
                stall_pend = 1'b0;
            end else begin
                if (stall_pend) begin
                    chk("axi_hold_valid", 64'(s_axis_tvalid), 64'd1);
                    chk("axi_hold_data", s_axis_tdata, stall_beat.data);
                    chk("axi_hold_keep", 64'(s_axis_tkeep), 64'(stall_beat.keep));
                    chk("axi_hold_last", 64'(s_axis_tlast), 64'(stall_beat.last));
                end
                stall_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
                stall_pend = s_axis_tvalid && !s_axis_tready;
                if (s_axis_tvalid && s_axis_tready) rx_q.push_back(stall_beat);
                if (s_resp != 2'b00 && m_resp_accept) begin
                    took = 1'b1;
                    n_taken++;
                    if (rsp_q.size() > 0) void'(rsp_q.pop_front());
                end
            end
            @(posedge clk);
            #1;
            case (tr_mode)
                1:       s_axis_tready = ~s_axis_tready;
                2:       s_axis_tready = 1'($urandom_range(0, 1));
                default: s_axis_tready = 1'b1;
            endcase
            if (rsp_q.size() == 0) begin
                s_resp = 2'b00;
                s_data = 32'h0;
            end else if ((s_resp != 2'b00 && !took) || gap_mode == 0 || $urandom_range(0, 2) != 0) begin
                s_resp = rsp_q[0].resp;
                s_data = rsp_q[0].data;
            end else begin
                s_resp = 2'b00;
                s_data = 32'h0BAD_0BAD;
            end
        end
    end

    // Present a descriptor until accepted; returns whether it was taken
    task automatic send_desc(input vec_t v, output bit acc);
        @(posedge clk);
        #1;
        desc_valid   = 1'b1;
        desc_len     = v.len;
        desc_req_id  = v.req_id;
        desc_tag     = v.tag;
        desc_lo_addr = v.lo;
        acc = 1'b0;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = desc_ready;
            @(posedge clk);
            #1;
        end
        desc_valid = 1'b0;
    endtask

    // One complete TLP: queue responses, send descriptor, collect and compare beats
    task automatic run_tlp(input vec_t v, input string nm);
        int          n;
        int          lastcnt;
        bit          acc;
        bit          done;
        logic [31:0] e[$];
        beat_t       exp_q[$];
        logic [31:0] dw2;
        logic [1:0]  r;
        n = (v.len == 10'd0) ? 1024 : int'(v.len);
        rx_q.delete();
        n_taken  = 0;
        tr_mode  = v.tr_mode;
        gap_mode = v.gap;
        for (int i = 0; i < n; i++) begin
            r = (i == v.err_idx) ? v.err_code : 2'b01;
            rsp_q.push_back({r, v.base + 32'(i)});
            e.push_back(r[1] ? 32'hFFFF_FFFF : v.base + 32'(i));
        end
        dw2 = {v.req_id, v.tag, 1'b0, v.lo};
        exp_q.push_back({e[0], dw2, 8'hFF, n == 1});
        for (int i = 1; i < n; i += 2) begin
            if (i + 1 < n) exp_q.push_back({e[i+1], e[i], 8'hFF, i + 2 == n});
            else           exp_q.push_back({32'h0, e[i], 8'h0F, 1'b1});
        end

        send_desc(v, acc);
        chk($sformatf("%s_desc_accept", nm), 64'(acc), 64'd1);
        @(negedge clk);
        chk($sformatf("%s_hdr_latency", nm), 64'(s_axis_tvalid), 64'd1);
        chk($sformatf("%s_ready_busy", nm), 64'(desc_ready), 64'd0);

        done = 1'b0;
        for (int c = 0; c < 8 * n + 100 && !done; c++) begin
            @(posedge clk);
            #1;
            done = (rx_q.size() > 0) && rx_q[rx_q.size()-1].last;
        end
        chk($sformatf("%s_tlast_seen", nm), 64'(done), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk($sformatf("%s_ready_idle", nm), 64'(desc_ready), 64'd1);
        chk($sformatf("%s_tvalid_idle", nm), 64'(s_axis_tvalid), 64'd0);
        chk($sformatf("%s_err_seen", nm), 64'(err_seen), 64'(v.exp_err));
        chk($sformatf("%s_dw_taken", nm), 64'(n_taken), 64'(n));
        chk($sformatf("%s_beat_count", nm), 64'(rx_q.size()), 64'(v.exp_nbeats));

        lastcnt = 0;
        foreach (rx_q[i]) if (rx_q[i].last) lastcnt++;
        chk($sformatf("%s_tlast_count", nm), 64'(lastcnt), 64'd1);

        if (rx_q.size() > 0) begin
            chk($sformatf("%s_beat0_data", nm), rx_q[0].data, v.exp_beat0);
            chk($sformatf("%s_beat0_keep", nm), 64'(rx_q[0].keep), 64'hFF);
            chk($sformatf("%s_final_keep", nm), 64'(rx_q[rx_q.size()-1].keep), 64'(v.exp_last_keep));
        end
        for (int i = 1; i < rx_q.size() && i - 1 < exp_q.size(); i++) begin
            chk($sformatf("%s_beat%0d_data", nm, i), rx_q[i].data, exp_q[i-1].data);
            chk($sformatf("%s_beat%0d_keep", nm, i), 64'(rx_q[i].keep), 64'(exp_q[i-1].keep));
            chk($sformatf("%s_beat%0d_last", nm, i), 64'(rx_q[i].last), 64'(exp_q[i-1].last));
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit    acc;
        bit    ok;
        int    lastcnt;
        vec_t  v8;

        //         len    req_id    tag    lo     base           err cd     tr gap  beat0                    nb   lastkeep err
        vecs[0] = '{10'd1, 16'h0200, 8'h05, 7'h04, 32'hDEADBEEF, -1, 2'b00, 0, 0, 64'h0100_0004_4A00_0001, 2,   8'hFF, 1'b0};
        vecs[1] = '{10'd4, 16'h1234, 8'hA5, 7'h7F, 32'h00000001, -1, 2'b00, 0, 0, 64'h0100_0010_4A00_0004, 4,   8'h0F, 1'b0};
        vecs[2] = '{10'd3, 16'hBEEF, 8'h3C, 7'h10, 32'h10000000, -1, 2'b00, 1, 0, 64'h0100_000C_4A00_0003, 3,   8'hFF, 1'b0};
        vecs[3] = '{10'd2, 16'h0001, 8'h00, 7'h00, 32'hCAFE0000,  1, 2'b11, 0, 0, 64'h0100_0008_4A00_0002, 3,   8'h0F, 1'b1};
        vecs[4] = '{10'd5, 16'hFFFF, 8'hFF, 7'h55, 32'h55550000, -1, 2'b00, 2, 1, 64'h0100_0014_4A00_0005, 4,   8'hFF, 1'b1};
        vecs[5] = '{10'd0, 16'h0300, 8'h11, 7'h22, 32'h00000000, -1, 2'b00, 0, 0, 64'h0100_0000_4A00_0000, 514, 8'h0F, 1'b1};
        vecs[6] = '{10'd6, 16'h4321, 8'h80, 7'h01, 32'hA0000000, -1, 2'b00, 1, 1, 64'h0100_0018_4A00_0006, 5,   8'h0F, 1'b1};
        vpost[0] = '{10'd1, 16'h0ABC, 8'h42, 7'h3F, 32'h13579BDF, -1, 2'b00, 0, 0, 64'h0100_0004_4A00_0001, 2,   8'hFF, 1'b0};
        vpost[1] = '{10'd1, 16'h0001, 8'h01, 7'h01, 32'h2468ACE0,  0, 2'b10, 2, 1, 64'h0100_0004_4A00_0001, 2,   8'hFF, 1'b1};
        v8       = '{10'd8, 16'h0777, 8'h77, 7'h07, 32'h70000000, -1, 2'b00, 0, 0, 64'h0100_0020_4A00_0008, 0,   8'hFF, 1'b0};

        reset = 1'b1;
        desc_valid = 1'b0;
        desc_len = '0;
        desc_req_id = '0;
        desc_tag = '0;
        desc_lo_addr = '0;
        s_resp = 2'b00;
        s_data = '0;
        s_axis_tready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_desc_ready", 64'(desc_ready), 64'd0);
        chk("rst_tvalid", 64'(s_axis_tvalid), 64'd0);
        chk("rst_accept", 64'(m_resp_accept), 64'd0);
        chk("rst_tlast", 64'(s_axis_tlast), 64'd0);
        chk("rst_err_seen", 64'(err_seen), 64'd0);
        chk("rst_tdata", s_axis_tdata, 64'd0);
        chk("rst_tkeep", 64'(s_axis_tkeep), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_release_ready", 64'(desc_ready), 64'd1);

        for (int k = 0; k < 7; k++) run_tlp(vecs[k], $sformatf("v%0d", k));

        // Reset in the middle of a len=8 TLP, with a stray descriptor held while busy
        rx_q.delete();
        n_taken  = 0;
        tr_mode  = 0;
        gap_mode = 0;
        for (int i = 0; i < 8; i++) rsp_q.push_back({2'b01, 32'h7000_0000 + 32'(i)});
        send_desc(v8, acc);
        chk("mid_desc_accept", 64'(acc), 64'd1);
        desc_valid   = 1'b1;
        desc_len     = 10'd3;
        desc_req_id  = 16'hDEAD;
        desc_tag     = 8'hEE;
        desc_lo_addr = 7'h11;
        @(negedge clk);
        chk("mid_ready_busy", 64'(desc_ready), 64'd0);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(posedge clk);
            #1;
            ok = (n_taken >= 2);
        end
        chk("mid_two_dws", 64'(ok), 64'd1);
        reset      = 1'b1;
        desc_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_tvalid", 64'(s_axis_tvalid), 64'd0);
        chk("mid_rst_tlast", 64'(s_axis_tlast), 64'd0);
        chk("mid_rst_accept", 64'(m_resp_accept), 64'd0);
        chk("mid_rst_ready", 64'(desc_ready), 64'd0);
        chk("mid_rst_err", 64'(err_seen), 64'd0);
        lastcnt = 0;
        foreach (rx_q[i]) if (rx_q[i].last) lastcnt++;
        chk("mid_no_tlast", 64'(lastcnt), 64'd0);
        if (rx_q.size() > 0) chk("mid_hdr_beat", rx_q[0].data, v8.exp_beat0);
        else chk("mid_hdr_present", 64'(rx_q.size()), 64'd1);
        rsp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);

        run_tlp(vpost[0], "post_clean");
        run_tlp(vpost[1], "post_fail");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
